// File: rtl/l2_mshr_alloc.sv
// l2_mshr_alloc
//   Allocator and free-list for the L2 MSHR entries. It hands out the lowest
//   free entry on request, reclaims entries on free, and produces the
//   add_mshr_entry / incr_mshr_cnt / mshr_i pulses for the L2 register block.
//   A free that collides with a grant is parked in a one-entry skid and
//   applied on the first cycle without a grant. This keeps the two
//   register-block pulses mutually exclusive.
//
//   Optional feature macro: L2_MSHR_FREE_CHECK_EN
//     defined   -> frees of non-busy entries are dropped and the sticky
//                  o_err_free flag is set
//     undefined -> no check is made and o_err_free is tied low
//
// Ports
//   i_clk              clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_alloc_req        request a free entry this cycle
//   o_alloc_gnt        entry granted this cycle (combinational)
//   o_alloc_idx        granted index, valid with o_alloc_gnt
//   i_free_valid       release entry i_free_idx
//   o_free_ready       free accepted this cycle (registered)
//   i_free_idx         entry being released
//   o_add_mshr_entry   count-down pulse to the register block (= o_alloc_gnt)
//   o_incr_mshr_cnt    count-up pulse, one per applied free
//   o_mshr_i           index of the applied free, valid with o_incr_mshr_cnt
//   o_busy             per-entry allocated bitmap (registered)
//   o_free_cnt         number of free entries (registered)
//   o_full             o_free_cnt == 0
//   o_err_free         sticky illegal-free flag
module l2_mshr_alloc #(
  parameter int N_ENTRIES = 4,
  parameter int IDX_BITS  = $clog2(N_ENTRIES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc_req,
  output logic                 o_alloc_gnt,
  output logic [IDX_BITS-1:0]  o_alloc_idx,
  input  logic                 i_free_valid,
  output logic                 o_free_ready,
  input  logic [IDX_BITS-1:0]  i_free_idx,
  output logic                 o_add_mshr_entry,
  output logic                 o_incr_mshr_cnt,
  output logic [IDX_BITS-1:0]  o_mshr_i,
  output logic [N_ENTRIES-1:0] o_busy,
  output logic [IDX_BITS:0]    o_free_cnt,
  output logic                 o_full,
  output logic                 o_err_free
);

  logic [N_ENTRIES-1:0] r_busy;
  logic [IDX_BITS:0]    r_free_cnt;
  logic [IDX_BITS-1:0]  r_next_idx;
  logic                 r_skid_vld;
  logic [IDX_BITS-1:0]  r_skid_idx;

  logic                 w_gnt;
  logic                 w_port_acc;
  logic                 w_port_legal;
  logic                 w_skid_apply;
  logic                 w_port_apply;
  logic                 w_skid_load;
  logic                 w_apply;
  logic [IDX_BITS-1:0]  w_apply_idx;
  logic [N_ENTRIES-1:0] w_busy_next;
  logic [IDX_BITS:0]    w_cnt_next;
  logic [IDX_BITS-1:0]  w_next_idx;

  assign o_full      = (r_free_cnt == '0);
  assign w_gnt       = i_alloc_req && !o_full;
  // A port free is only taken while the skid is empty (o_free_ready = 1).
  assign w_port_acc  = i_free_valid && !r_skid_vld;

`ifdef L2_MSHR_FREE_CHECK_EN
  logic r_err_free;
  logic w_free_err;
  // A same-cycle grant index is never busy. The explicit compare keeps the
  // intent visible.
  assign w_port_legal = r_busy[i_free_idx] && !(w_gnt && (i_free_idx == r_next_idx));
  assign w_free_err   = w_port_acc && !w_port_legal;
  assign o_err_free   = r_err_free;
`else
  assign w_port_legal = 1'b1;
  assign o_err_free   = 1'b0;
`endif

  // The skid always wins over the port. Nothing is applied during a grant,
  // so add/incr can never coincide.
  assign w_skid_apply = r_skid_vld && !w_gnt;
  assign w_port_apply = w_port_acc && w_port_legal && !w_gnt;
  assign w_skid_load  = w_port_acc && w_port_legal && w_gnt;
  assign w_apply      = w_skid_apply || w_port_apply;
  assign w_apply_idx  = r_skid_vld ? r_skid_idx : i_free_idx;

  always_comb begin
    w_busy_next = r_busy;
    if (w_gnt)   w_busy_next[r_next_idx]  = 1'b1;
    if (w_apply) w_busy_next[w_apply_idx] = 1'b0;
  end

  assign w_cnt_next = r_free_cnt - (IDX_BITS+1)'(w_gnt) + (IDX_BITS+1)'(w_apply);

  // Lowest free index of the next-state bitmap. The value is held when no
  // entry is free, so alloc_idx keeps its last value while full.
  always_comb begin
    w_next_idx = r_next_idx;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!w_busy_next[i]) w_next_idx = IDX_BITS'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_free_cnt <= (IDX_BITS+1)'(N_ENTRIES);
      r_next_idx <= '0;
      r_skid_vld <= 1'b0;
      r_skid_idx <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_free_cnt <= w_cnt_next;
      r_next_idx <= w_next_idx;
      if (w_skid_load) begin
        r_skid_vld <= 1'b1;
        r_skid_idx <= i_free_idx;
      end else if (w_skid_apply) begin
        r_skid_vld <= 1'b0;
      end
    end
  end

`ifdef L2_MSHR_FREE_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_err_free <= 1'b0;
    else if (w_free_err) r_err_free <= 1'b1;
  end
`endif

  assign o_alloc_gnt      = w_gnt;
  assign o_alloc_idx      = r_next_idx;
  assign o_add_mshr_entry = w_gnt;
  assign o_incr_mshr_cnt  = w_apply;
  assign o_mshr_i         = w_apply ? w_apply_idx : '0;
  assign o_free_ready     = !r_skid_vld;
  assign o_busy           = r_busy;
  assign o_free_cnt       = r_free_cnt;

endmodule
